uart_cmd_parser: RTL
====================

// Module: uart_cmd_parser
// PURPOSE
// - Sits directly downstream of the UART receiver. Consumes its received bytes via the
//   converted/flush handshake and assembles 5-byte joint command frames.
// - Frame format: SYNC, JOINT_ID, ANGLE_HI, ANGLE_LO, CSUM.
//   CSUM = JOINT_ID ^ ANGLE_HI ^ ANGLE_LO.
// - Emits a one-cycle cmd_valid pulse with joint/angle for the servo control stage.
// - Flags malformed frames.
// PARAMETERS
// SYNC_BYTE       8'hA5    frame start marker
// NUM_JOINTS      6        valid JOINT_ID range is 0..NUM_JOINTS-1
// ANGLE_MAX       16'd3600 max legal angle (0.1 deg units)
// TIMEOUT_CYCLES  100000   max i_clk cycles between bytes inside a frame (1 ms @ 100 MHz)
// PORTS
// i_clk       in   1   system clock (100 MHz)
// i_rst       in   1   synchronous, active-high reset
// rx_data     in   8   byte from the UART receiver (data)
// rx_converted in  1   receiver has a byte ready (converted)
// rx_valid    in   1   receiver parity result (data_valid); sampled with rx_data
// rx_flush    out  1   release request to the receiver (flush)
// cmd_valid   out  1   one-cycle pulse: new legal command on cmd_joint/cmd_angle
// cmd_joint   out  3   joint index, held until the next cmd_valid
// cmd_angle   out  16  target angle {HI,LO}, held until the next cmd_valid
// frame_err   out  1   one-cycle pulse: frame discarded
// err_code    out  2   0 parity, 1 checksum, 2 id/angle range, 3 timeout; held until next frame_err
// busy        out  1   high when the parser state is not WAIT_SYNC
// BEHAVIOUR
// - Reset values: rx_flush=0, cmd_valid=0, cmd_joint=0, cmd_angle=0, frame_err=0,
//   err_code=0, busy=0. Parser state WAIT_SYNC, handshake state HS_IDLE, timeout counter 0.
// - Byte handshake (4-phase). The receiver only updates on its own sample ticks, so it may
//   take many i_clk cycles to respond.
//   - HS_IDLE & rx_converted=1: latch rx_data/rx_valid, set rx_flush<=1, go to HS_WAIT.
//     The parser consumes the byte on this same edge.
//   - HS_WAIT: hold rx_flush=1 until rx_converted=0, then rx_flush<=0 and go to HS_IDLE.
//   - A byte is never consumed twice. While in HS_WAIT, rx_converted=1 is ignored.
// - Parser FSM (advances only on a consumed byte, or on timeout):
//   - WAIT_SYNC: byte==SYNC_BYTE goes to GET_ID. Any other byte is dropped silently,
//     with no error.
//   - GET_ID: store id, go to GET_HI.
//   - GET_HI: store hi, go to GET_LO.
//   - GET_LO: store lo, go to GET_CSUM.
//   - GET_CSUM: run the checks in this order:
//     parity of any frame byte bad, then checksum mismatch, then id>=NUM_JOINTS or
//     {hi,lo}>ANGLE_MAX.
//     - Any check fails: frame_err pulse with that err_code.
//     - All pass: cmd_valid pulse, cmd_joint<=id[2:0], cmd_angle<={hi,lo}.
//     - Always return to WAIT_SYNC.
// - Parity: a sticky per-frame flag records rx_valid=0 on any byte. The frame runs to
//   GET_CSUM, then reports err_code 0. The flag clears on entering GET_ID.
// - Latency: the consuming edge is the one where HS_IDLE sees rx_converted=1 on the
//   CSUM byte. cmd_valid/frame_err is high for exactly the following cycle.
// - Timeout:
//   - The counter clears on every consumed byte and in WAIT_SYNC. It increments
//     elsewhere and saturates.
//   - At TIMEOUT_CYCLES-1: frame_err, err_code=3, state WAIT_SYNC.
//   - If a byte is consumed on that same edge, the byte wins and the timeout is cancelled.
// - Checksum is 8-bit XOR with no carry. The SYNC byte is excluded.
// - A SYNC_BYTE value mid-frame is treated as ordinary data (no resync).
// - Reset mid-frame: partial frame discarded and rx_flush dropped. If rx_converted is
//   still high after reset, that byte is consumed fresh in WAIT_SYNC.
// - cmd_valid and frame_err are never high in the same cycle.
// TESTING
// 1 Reset then A5 02 01 2C 2F (each with rx_valid=1) -> one cmd_valid, cmd_joint=2,
//   cmd_angle=16'h012C, frame_err never high.
// 2 A5 02 01 2C 2E -> frame_err pulse, err_code=1, no cmd_valid, busy=0 afterwards.
// 3 A5 07 00 10 17 -> err_code=2. Then A5 00 0E 11 1F (angle 3601) -> err_code=2.
// 4 Junk 00 33 then A5 01 00 64 65 -> junk ignored silently, cmd_joint=1, cmd_angle=100.
// 5 A5 03, then idle 100000 cycles -> frame_err, err_code=3. Next full frame accepted.
// 6 Handshake: receiver model holds converted 60 cycles after flush
//   -> exactly one byte consumed, flush held throughout.
//   Byte with rx_valid=0 -> err_code=0. Assert i_rst mid-frame
//   -> all outputs at reset values, next frame parses.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Joint command frame parser downstream of the UART receiver: 4-phase byte handshake,
// 5-byte frame assembly (SYNC, ID, HI, LO, CSUM), validation and inter-byte timeout.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          NUM_JOINTS     = 6,
  parameter logic [15:0] ANGLE_MAX      = 16'd3600,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_converted,
  input  logic        rx_valid,
  output logic        rx_flush,
  output logic        cmd_valid,
  output logic [2:0]  cmd_joint,
  output logic [15:0] cmd_angle,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    GET_ID    = 3'd1,
    GET_HI    = 3'd2,
    GET_LO    = 3'd3,
    GET_CSUM  = 3'd4
  } state_t;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_WAIT = 1'b1
  } hs_t;

  // 8-bit XOR over the payload bytes; SYNC is not part of the sum
  function automatic logic [7:0] frame_csum(input logic [7:0] id, input logic [7:0] hi,
                                            input logic [7:0] lo);
    return id ^ hi ^ lo;
  endfunction

  state_t         state_r, state_nx_s;
  hs_t            hs_r, hs_nx_s;
  logic           flush_r, flush_nx_s;
  logic           consume_s;
  logic [TW-1:0]  tmo_r, tmo_nx_s;
  logic           timeout_s;
  logic [7:0]     id_r, id_nx_s;
  logic [7:0]     hi_r, hi_nx_s;
  logic [7:0]     lo_r, lo_nx_s;
  logic           par_bad_r, par_bad_nx_s;
  logic           cmd_valid_r, cmd_valid_nx_s;
  logic [2:0]     cmd_joint_r, cmd_joint_nx_s;
  logic [15:0]    cmd_angle_r, cmd_angle_nx_s;
  logic           frame_err_r, frame_err_nx_s;
  logic [1:0]     err_code_r, err_code_nx_s;
  logic           busy_r;

  // Receiver handshake: accept one byte, then hold flush until converted drops
  always_comb begin
    hs_nx_s    = hs_r;
    flush_nx_s = flush_r;
    consume_s  = 1'b0;
    case (hs_r)
      HS_IDLE: begin
        if (rx_converted) begin
          consume_s  = 1'b1;
          hs_nx_s    = HS_WAIT;
          flush_nx_s = 1'b1;
        end else begin
          hs_nx_s    = HS_IDLE;
          flush_nx_s = 1'b0;
        end
      end
      HS_WAIT: begin
        if (!rx_converted) begin
          hs_nx_s    = HS_IDLE;
          flush_nx_s = 1'b0;
        end else begin
          hs_nx_s    = HS_WAIT;
          flush_nx_s = 1'b1;
        end
      end
      default: begin
        hs_nx_s    = HS_IDLE;
        flush_nx_s = 1'b0;
      end
    endcase
  end

  // Inter-byte timeout counter; a byte consumed on the expiry edge cancels the timeout
  always_comb begin
    timeout_s = (state_r != WAIT_SYNC) && (tmo_r == TW'(TIMEOUT_CYCLES - 1)) && !consume_s;
    if (consume_s || (state_r == WAIT_SYNC)) begin
      tmo_nx_s = {TW{1'b0}};
    end else if (tmo_r != {TW{1'b1}}) begin
      tmo_nx_s = tmo_r + TW'(1);
    end else begin
      tmo_nx_s = tmo_r;
    end
  end

  // Frame parser next-state and result generation
  always_comb begin
    state_nx_s     = state_r;
    id_nx_s        = id_r;
    hi_nx_s        = hi_r;
    lo_nx_s        = lo_r;
    par_bad_nx_s   = par_bad_r;
    cmd_valid_nx_s = 1'b0;
    cmd_joint_nx_s = cmd_joint_r;
    cmd_angle_nx_s = cmd_angle_r;
    frame_err_nx_s = 1'b0;
    err_code_nx_s  = err_code_r;
    if (consume_s) begin
      case (state_r)
        WAIT_SYNC: begin
          if (rx_data == SYNC_BYTE) begin
            state_nx_s   = GET_ID;
            par_bad_nx_s = ~rx_valid;
          end else begin
            state_nx_s   = WAIT_SYNC;
          end
        end
        GET_ID: begin
          id_nx_s      = rx_data;
          par_bad_nx_s = par_bad_r | ~rx_valid;
          state_nx_s   = GET_HI;
        end
        GET_HI: begin
          hi_nx_s      = rx_data;
          par_bad_nx_s = par_bad_r | ~rx_valid;
          state_nx_s   = GET_LO;
        end
        GET_LO: begin
          lo_nx_s      = rx_data;
          par_bad_nx_s = par_bad_r | ~rx_valid;
          state_nx_s   = GET_CSUM;
        end
        GET_CSUM: begin
          state_nx_s = WAIT_SYNC;
          // Check priority: parity, checksum, then id/angle range
          if (par_bad_r || !rx_valid) begin
            frame_err_nx_s = 1'b1;
            err_code_nx_s  = 2'd0;
          end else if (frame_csum(id_r, hi_r, lo_r) != rx_data) begin
            frame_err_nx_s = 1'b1;
            err_code_nx_s  = 2'd1;
          end else if ((id_r >= 8'(NUM_JOINTS)) || ({hi_r, lo_r} > ANGLE_MAX)) begin
            frame_err_nx_s = 1'b1;
            err_code_nx_s  = 2'd2;
          end else begin
            cmd_valid_nx_s = 1'b1;
            cmd_joint_nx_s = id_r[2:0];
            cmd_angle_nx_s = {hi_r, lo_r};
          end
        end
        default: begin
          state_nx_s = WAIT_SYNC;
        end
      endcase
    end else if (timeout_s) begin
      state_nx_s     = WAIT_SYNC;
      frame_err_nx_s = 1'b1;
      err_code_nx_s  = 2'd3;
    end else begin
      state_nx_s     = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= WAIT_SYNC;
      hs_r        <= HS_IDLE;
      flush_r     <= 1'b0;
      tmo_r       <= {TW{1'b0}};
      id_r        <= 8'd0;
      hi_r        <= 8'd0;
      lo_r        <= 8'd0;
      par_bad_r   <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_joint_r <= 3'd0;
      cmd_angle_r <= 16'd0;
      frame_err_r <= 1'b0;
      err_code_r  <= 2'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      hs_r        <= hs_nx_s;
      flush_r     <= flush_nx_s;
      tmo_r       <= tmo_nx_s;
      id_r        <= id_nx_s;
      hi_r        <= hi_nx_s;
      lo_r        <= lo_nx_s;
      par_bad_r   <= par_bad_nx_s;
      cmd_valid_r <= cmd_valid_nx_s;
      cmd_joint_r <= cmd_joint_nx_s;
      cmd_angle_r <= cmd_angle_nx_s;
      frame_err_r <= frame_err_nx_s;
      err_code_r  <= err_code_nx_s;
      busy_r      <= (state_nx_s != WAIT_SYNC);
    end
  end

  assign rx_flush  = flush_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_joint = cmd_joint_r;
  assign cmd_angle = cmd_angle_r;
  assign frame_err = frame_err_r;
  assign err_code  = err_code_r;
  assign busy      = busy_r;

endmodule
